// File: rtl/wallace16_pkg.sv
// Shared constants for the sequential 16x16 multiplier:
// FSM state encoding, partial-product shifts, carry-save helpers.
package wallace16_pkg;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PP0  = 3'd1;
  localparam logic [2:0] S_PP1  = 3'd2;
  localparam logic [2:0] S_PP2  = 3'd3;
  localparam logic [2:0] S_PP3  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [4:0] SH_PP0 = 5'd0;
  localparam logic [4:0] SH_PP1 = 5'd8;
  localparam logic [4:0] SH_PP2 = 5'd8;
  localparam logic [4:0] SH_PP3 = 5'd16;

  function automatic logic [15:0] csa_s(
    input logic [15:0] x,
    input logic [15:0] y,
    input logic [15:0] z
  );
    return x ^ y ^ z;
  endfunction

  // Carries leaving bit 15 are dropped; the final sum of an
  // 8x8 product always fits in 16 bits.
  function automatic logic [15:0] csa_c(
    input logic [15:0] x,
    input logic [15:0] y,
    input logic [15:0] z
  );
    return ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

endpackage

// File: rtl/wallace16_seq_mul8.sv
// Wallace: combinational 8x8 unsigned Wallace-tree multiplier.
// Ports: a_i, b_i (8-bit operands), p_o (16-bit product).
module Wallace
  import wallace16_pkg::*;
(
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic [15:0] p_o
);

  logic [15:0] pp [8];
  logic [15:0] s1a, c1a, s1b, c1b;
  logic [15:0] s2a, c2a, s2b, c2b;
  logic [15:0] s3, c3, s4, c4;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      pp[i] = {8'b0, a_i & {8{b_i[i]}}} << i;
    end
  end

  // 8 rows -> 6 -> 4 -> 3 -> 2, then one carry-propagate add.
  assign s1a = csa_s(pp[0], pp[1], pp[2]);
  assign c1a = csa_c(pp[0], pp[1], pp[2]);
  assign s1b = csa_s(pp[3], pp[4], pp[5]);
  assign c1b = csa_c(pp[3], pp[4], pp[5]);

  assign s2a = csa_s(s1a, c1a, s1b);
  assign c2a = csa_c(s1a, c1a, s1b);
  assign s2b = csa_s(c1b, pp[6], pp[7]);
  assign c2b = csa_c(c1b, pp[6], pp[7]);

  assign s3 = csa_s(s2a, c2a, s2b);
  assign c3 = csa_c(s2a, c2a, s2b);

  assign s4 = csa_s(s3, c3, c2b);
  assign c4 = csa_c(s3, c3, c2b);

  assign p_o = s4 + c4;

endmodule

// File: rtl/wallace16_seq.sv
// 16x16 unsigned multiplier time-sharing one 8x8 Wallace tree.
// Ports: clk, rst_n, in_valid/in_ready/a/b, out_valid/out_ready/out, busy.
module wallace16_seq
  import wallace16_pkg::*;
#(
  parameter bit ZERO_SKIP = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out,
  output logic        busy
);

  logic [2:0]  state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [31:0] acc_q, acc_d;

  logic [7:0]  op_a, op_b;
  logic [4:0]  sh;
  logic [15:0] prod;
  logic [31:0] term;
  logic        accept;
  logic        skip;

  assign in_ready  = (state_q == S_IDLE)
                   | ((state_q == S_DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign skip      = ZERO_SKIP & ((a == 16'd0) | (b == 16'd0));
  assign out_valid = (state_q == S_DONE);
  assign out       = acc_q;
  assign busy      = (state_q != S_IDLE);

  always_comb begin
    op_a = a_q[7:0];
    op_b = b_q[7:0];
    sh   = SH_PP0;
    case (state_q)
      S_PP1: begin
        op_a = a_q[15:8];
        sh   = SH_PP1;
      end
      S_PP2: begin
        op_b = b_q[15:8];
        sh   = SH_PP2;
      end
      S_PP3: begin
        op_a = a_q[15:8];
        op_b = b_q[15:8];
        sh   = SH_PP3;
      end
      default: ;
    endcase
  end

  Wallace u_mul (
    .a_i (op_a),
    .b_i (op_b),
    .p_o (prod)
  );

  assign term = {16'b0, prod} << sh;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    if (accept) begin
      a_d     = a;
      b_d     = b;
      acc_d   = 32'd0;
      state_d = skip ? S_DONE : S_PP0;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_PP0: begin
          acc_d   = acc_q + term;
          state_d = S_PP1;
        end
        S_PP1: begin
          acc_d   = acc_q + term;
          state_d = S_PP2;
        end
        S_PP2: begin
          acc_d   = acc_q + term;
          state_d = S_PP3;
        end
        S_PP3: begin
          acc_d   = acc_q + term;
          state_d = S_DONE;
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= 16'd0;
      b_q     <= 16'd0;
      acc_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: tb/tb_wallace16_seq.sv
// Directed bench for wallace16_seq (ZERO_SKIP=1 and ZERO_SKIP=0).
// Drives and samples 1ns after each rising edge.
module tb_wallace16_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic        use_z;
  logic [15:0] a, b;

  logic        ir1, ov1, bz1;
  logic [31:0] o1;
  logic        ir0, ov0, bz0;
  logic [31:0] o0;

  logic        c_ir, c_ov, c_bz;
  logic [31:0] c_out;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wallace16_seq #(.ZERO_SKIP(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid & ~use_z),
    .in_ready  (ir1),
    .a         (a),
    .b         (b),
    .out_valid (ov1),
    .out_ready (out_ready),
    .out       (o1),
    .busy      (bz1)
  );

  wallace16_seq #(.ZERO_SKIP(1'b0)) dut_nz (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid & use_z),
    .in_ready  (ir0),
    .a         (a),
    .b         (b),
    .out_valid (ov0),
    .out_ready (out_ready),
    .out       (o0),
    .busy      (bz0)
  );

  assign c_ir  = use_z ? ir0 : ir1;
  assign c_ov  = use_z ? ov0 : ov1;
  assign c_bz  = use_z ? bz0 : bz1;
  assign c_out = use_z ? o0  : o1;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called 1ns after an accept edge; lat counts edges since accept.
  task automatic wait_valid(output int lat, output int bc);
    lat = 1;
    bc  = 0;
    if (c_bz) bc++;
    while (!c_ov && lat < 20) begin
      tick();
      lat++;
      if (c_bz) bc++;
    end
  endtask

  task automatic run(
    input logic        z,
    input logic [15:0] av,
    input logic [15:0] bv,
    input logic [31:0] exp,
    input int          exp_lat,
    input string       tag
  );
    int lat, bc;
    use_z    = z;
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid(lat, bc);
    check({tag, "_out"}, c_out, exp);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy"}, 32'(bc), 32'(exp_lat));
  endtask

  initial begin
    int lat, bc;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    use_z     = 1'b0;
    a         = 16'd0;
    b         = 16'd0;
    #3;
    check("rst_ov", 32'(ov1), 32'd0);
    check("rst_out", o1, 32'd0);
    check("rst_busy", 32'(bz1), 32'd0);
    check("rst_ir", 32'(ir1), 32'd1);
    #20 rst_n = 1'b1;
    tick();

    run(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 5, "ffff");
    tick();
    check("idle_ov", 32'(ov1), 32'd0);
    run(1'b0, 16'h1234, 16'h5678, 32'h06260060, 5, "1234");
    tick();
    run(1'b0, 16'h0000, 16'hABCD, 32'h0, 1, "zs1a");
    tick();
    run(1'b0, 16'h5555, 16'h0000, 32'h0, 1, "zs1b");
    tick();
    run(1'b1, 16'h0000, 16'hABCD, 32'h0, 5, "zs0");
    tick();
    use_z = 1'b0;

    // backpressure
    out_ready = 1'b0;
    run(1'b0, 16'h0003, 16'h0005, 32'd15, 5, "bp");
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_ov", 32'(ov1), 32'd1);
      check("bp_out", o1, 32'd15);
      check("bp_ir", 32'(ir1), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_rel_ov", 32'(ov1), 32'd0);
    check("bp_rel_busy", 32'(bz1), 32'd0);
    check("bp_rel_ir", 32'(ir1), 32'd1);

    // back-to-back, operands change while busy
    a        = 16'h0002;
    b        = 16'h0003;
    in_valid = 1'b1;
    tick();
    a = 16'h0100;
    b = 16'h0100;
    wait_valid(lat, bc);
    check("b2b1_out", o1, 32'h6);
    check("b2b1_lat", 32'(lat), 32'd5);
    check("b2b1_ir", 32'(ir1), 32'd1);
    tick();
    in_valid = 1'b0;
    check("b2b2_ov0", 32'(ov1), 32'd0);
    check("b2b2_busy", 32'(bz1), 32'd1);
    wait_valid(lat, bc);
    check("b2b2_out", o1, 32'h00010000);
    check("b2b2_lat", 32'(lat), 32'd5);
    tick();

    // reset during PP2
    a        = 16'h1234;
    b        = 16'h5678;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("pp2_busy", 32'(bz1), 32'd1);
    rst_n = 1'b0;
    #1;
    check("ar_ov", 32'(ov1), 32'd0);
    check("ar_busy", 32'(bz1), 32'd0);
    check("ar_out", o1, 32'd0);
    check("ar_ir", 32'(ir1), 32'd1);
    tick();
    tick();
    check("ar_hold_ov", 32'(ov1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      check("ar_noout", 32'(ov1), 32'd0);
      tick();
    end
    run(1'b0, 16'h00FF, 16'h00FF, 32'h0000FE01, 5, "post_rst");
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/wallace16_seq.md
WALLACE16_SEQ -- requirements
Module: wallace16_seq

Interface
REQ-001 SHALL have parameter: ZERO_SKIP, default 1, when 1 a zero operand bypasses the partial-product cycles.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  operand pair offered.
REQ-005 SHALL have port: in_ready  output  1  block can accept operands this cycle.
REQ-006 SHALL have port: a  input  16  unsigned multiplicand.
REQ-007 SHALL have port: b  input  16  unsigned multiplier.
REQ-008 SHALL have port: out_valid  output  1  product available.
REQ-009 SHALL have port: out_ready  input  1  consumer takes product this cycle.
REQ-010 SHALL have port: out  output  32  unsigned product a*b.
REQ-011 SHALL have port: busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL time-share one 8x8 multiplier instance over four cycles to form the 16x16 product.
REQ-013 SHALL implement FSM states IDLE, PP0, PP1, PP2, PP3, DONE.
REQ-014 SHALL accept operands when in_valid & in_ready; a, b latched into internal registers, accumulator cleared.
REQ-015 SHALL drive in_ready = (state==IDLE) | (state==DONE & out_ready).
REQ-016 SHALL transition IDLE->PP0 on accept; IDLE stays IDLE otherwise.
REQ-017 SHALL compute per state: PP0 aL*bL <<0, PP1 aH*bL <<8, PP2 aL*bH <<8, PP3 aH*bH <<16; each term added into the 32-bit accumulator.
REQ-018 SHALL advance PP0->PP1->PP2->PP3->DONE unconditionally, one state per cycle.
REQ-019 SHALL use 32-bit unsigned accumulation; no overflow possible, no carry-out retained.
REQ-020 SHALL assert out_valid only in DONE; out equals the accumulator and SHALL stay stable while out_valid & !out_ready.
REQ-021 SHALL leave DONE on out_ready: to PP0 if in_valid accepted the same cycle, else to IDLE.
REQ-022 SHALL give latency of 5 cycles from accept edge to out_valid high (PP0..PP3, then DONE).
REQ-023 SHALL, when ZERO_SKIP=1 and a==0 or b==0 at accept, go directly to DONE with accumulator 0 (out_valid the cycle after accept).
REQ-024 SHALL ignore a, b, in_valid while in PP0..PP3 and DONE except the REQ-021 case.

Reset
REQ-025 SHALL on rst_n low, immediately and asynchronously: state IDLE, accumulator 0, operand registers 0.
REQ-026 SHALL hold outputs during reset at out_valid 0, out 0, busy 0, in_ready 1.
REQ-027 SHALL abort any in-flight multiply on reset mid-operation, with no output ever produced for it.

Structure
REQ-028 SHALL place the FSM state encoding (3-bit localparams) and the shift amounts in a shared package wallace16_pkg.
REQ-029 SHALL instantiate the existing 8x8 Wallace multiplier module Wallace as its single sub-module; operand halves selected by a mux driven by state.
REQ-030 SHALL contain no combinational path from in_valid to out_valid.

Verification
REQ-031 SHALL test a=0xFFFF, b=0xFFFF -> out=0xFFFE0001, out_valid 5 cycles after accept.
REQ-032 SHALL test a=0x1234, b=0x5678 -> out=0x06260060; busy high for cycles 1-5.
REQ-033 SHALL test a=0x0000, b=0xABCD, ZERO_SKIP=1 -> out=0x00000000, out_valid 1 cycle after accept; with ZERO_SKIP=0 -> out_valid after 5 cycles.
REQ-034 SHALL test backpressure: out_ready low 3 cycles in DONE -> out and out_valid stable, in_ready 0; out_ready high -> returns to IDLE.
REQ-035 SHALL test back-to-back: in_valid held with 0x0002*0x0003 then 0x0100*0x0100 -> 0x00000006 then 0x00010000, second accept on the DONE handshake cycle.
REQ-036 SHALL test reset: rst_n low during PP2 -> state IDLE, out_valid 0 asynchronously; next operation 0x00FF*0x00FF -> 0x0000FE01.
